// File: rtl/la_pwrseq_if.sv
// Boundary signals of one switchable power domain: sequencer requests/feedback
// and the isolation, power, clock and reset controls it drives.
interface la_pwrseq_if;
  logic req_on;
  logic pwr_ack;
  logic iso;
  logic pwr_en;
  logic clken;
  logic dom_rst;
  logic is_on;
  logic busy;
  logic err;

  modport master (
    input  req_on, pwr_ack,
    output iso, pwr_en, clken, dom_rst, is_on, busy, err
  );

  modport slave (
    output req_on, pwr_ack,
    input  iso, pwr_en, clken, dom_rst, is_on, busy, err
  );
endinterface

// File: rtl/la_pwrseq.sv
// Power-domain sequencer: orders power-switch, clock enable, domain reset and
// isolation so isolation covers any unpowered, unclocked or reset interval.
module la_pwrseq #(
  parameter int unsigned ISO_DLY = 2,
  parameter int unsigned RST_DLY = 4,
  parameter int unsigned PWR_TO  = 16,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  la_pwrseq_if.master pif
);

  typedef enum logic [2:0] {
    S_OFF, S_PWRUP, S_RSTREL, S_ISOREL, S_ON, S_ISOSET, S_CLKOFF, S_PWRDN
  } state_t;

  // A timed state entered at edge e exits at edge e+DLY, i.e. when the
  // counter (cleared on entry) reads DLY-1.
  localparam logic [CW-1:0] ISO_LAST = CW'(ISO_DLY - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_DLY - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(PWR_TO - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  logic          iso_q, pwr_en_q, clken_q, dom_rst_q, is_on_q, busy_q;
  logic          iso_n, pwr_en_n, clken_n, dom_rst_n, is_on_n, busy_n;

  always_comb begin
    state_n = state;
    err_n   = err_q;
    case (state)
      S_OFF: begin
        if (pif.req_on) begin
          state_n = S_PWRUP;
          err_n   = 1'b0;
        end
      end
      S_PWRUP: begin
        if (pif.pwr_ack) begin
          state_n = S_RSTREL;
        end else if (PWR_TO != 0 && cnt == TO_LAST) begin
          state_n = S_OFF;
          err_n   = 1'b1;
        end
      end
      S_RSTREL: if (cnt == RST_LAST) state_n = S_ISOREL;
      S_ISOREL: if (cnt == ISO_LAST) state_n = S_ON;
      S_ON:     if (!pif.req_on) state_n = S_ISOSET;
      S_ISOSET: if (cnt == ISO_LAST) state_n = S_CLKOFF;
      S_CLKOFF: if (cnt == RST_LAST) state_n = S_PWRDN;
      S_PWRDN: begin
        if (!pif.pwr_ack) begin
          state_n = S_OFF;
        end else if (PWR_TO != 0 && cnt == TO_LAST) begin
          state_n = S_OFF;
          err_n   = 1'b1;
        end
      end
      default: state_n = S_OFF;
    endcase

    if (state_n != state)
      cnt_n = '0;
    else if (cnt == '1)
      cnt_n = cnt;
    else
      cnt_n = cnt + CW'(1);

    // Outputs are decoded from the next state so they register on the same edge.
    iso_n     = 1'b1;
    pwr_en_n  = 1'b0;
    clken_n   = 1'b0;
    dom_rst_n = 1'b1;
    is_on_n   = 1'b0;
    busy_n    = 1'b1;
    case (state_n)
      S_OFF:    busy_n = 1'b0;
      S_PWRUP:  pwr_en_n = 1'b1;
      S_RSTREL: begin pwr_en_n = 1'b1; clken_n = 1'b1; end
      S_ISOREL: begin pwr_en_n = 1'b1; clken_n = 1'b1; dom_rst_n = 1'b0; end
      S_ON: begin
        iso_n = 1'b0; pwr_en_n = 1'b1; clken_n = 1'b1; dom_rst_n = 1'b0;
        is_on_n = 1'b1; busy_n = 1'b0;
      end
      S_ISOSET: begin pwr_en_n = 1'b1; clken_n = 1'b1; dom_rst_n = 1'b0; end
      S_CLKOFF: pwr_en_n = 1'b1;
      S_PWRDN:  ;
      default:  busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OFF;
      cnt       <= '0;
      err_q     <= 1'b0;
      iso_q     <= 1'b1;
      pwr_en_q  <= 1'b0;
      clken_q   <= 1'b0;
      dom_rst_q <= 1'b1;
      is_on_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      err_q     <= err_n;
      iso_q     <= iso_n;
      pwr_en_q  <= pwr_en_n;
      clken_q   <= clken_n;
      dom_rst_q <= dom_rst_n;
      is_on_q   <= is_on_n;
      busy_q    <= busy_n;
    end
  end

  assign pif.iso     = iso_q;
  assign pif.pwr_en  = pwr_en_q;
  assign pif.clken   = clken_q;
  assign pif.dom_rst = dom_rst_q;
  assign pif.is_on   = is_on_q;
  assign pif.busy    = busy_q;
  assign pif.err     = err_q;

endmodule

// File: tb/tb_la_pwrseq.sv
// Directed and randomized checks of la_pwrseq against a timestamp-based
// model of the power-up / power-down sequences.
module tb_la_pwrseq;

  localparam int ISO = 2;
  localparam int RSTD = 3;
  localparam int TO = 8;

  localparam int M_OFF = 0;
  localparam int M_UP  = 1;
  localparam int M_ON  = 2;
  localparam int M_DN  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  la_pwrseq_if pif ();

  la_pwrseq #(.ISO_DLY(ISO), .RST_DLY(RSTD), .PWR_TO(TO), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  always #5 clk = ~clk;

  int n = 0;
  int compared = 0;
  int mismatched = 0;
  int mode = M_OFF;
  int t0 = 0;
  int ack_t = -1;
  bit m_err = 1'b0;

  // Mode changes are keyed on edge timestamps rather than per-state counters.
  task automatic model_edge();
    int pd;
    if (rst) begin
      mode = M_OFF;
      m_err = 1'b0;
    end else begin
      case (mode)
        M_OFF: if (pif.req_on) begin
          mode = M_UP; t0 = n; ack_t = -1; m_err = 1'b0;
        end
        M_UP: begin
          if (ack_t < 0) begin
            if (pif.pwr_ack) ack_t = n;
            else if (TO > 0 && n == t0 + TO) begin mode = M_OFF; m_err = 1'b1; end
          end else if (n == ack_t + RSTD + ISO) begin
            mode = M_ON;
          end
        end
        M_ON: if (!pif.req_on) begin mode = M_DN; t0 = n; end
        default: begin
          pd = t0 + ISO + RSTD;
          if (n > pd) begin
            if (!pif.pwr_ack) mode = M_OFF;
            else if (TO > 0 && n == pd + TO) begin mode = M_OFF; m_err = 1'b1; end
          end
        end
      endcase
    end
  endtask

  // {iso, pwr_en, clken, dom_rst, is_on, busy, err}
  function automatic logic [6:0] model_out();
    logic [5:0] v;
    case (mode)
      M_OFF: v = 6'b100100;
      M_UP: begin
        if (ack_t < 0) v = 6'b110101;
        else if (n - ack_t < RSTD) v = 6'b111101;
        else v = 6'b111001;
      end
      M_ON: v = 6'b011010;
      default: begin
        if (n - t0 < ISO) v = 6'b111001;
        else if (n - t0 < ISO + RSTD) v = 6'b110101;
        else v = 6'b100101;
      end
    endcase
    return {v, m_err};
  endfunction

  task automatic check_cycle();
    logic [6:0] obs;
    logic [6:0] exp;
    logic inv;
    obs = {pif.iso, pif.pwr_en, pif.clken, pif.dom_rst, pif.is_on, pif.busy, pif.err};
    exp = model_out();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL outputs edge=%0d observed=%b expected=%b", n, obs, exp);
    end
    inv = pif.iso | ~(~pif.pwr_en | ~pif.clken | pif.dom_rst);
    compared++;
    assert (inv === 1'b1) else begin
      mismatched++;
      $error("FAIL iso_invariant edge=%0d observed=%b expected=1", n, inv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  initial begin
    int stuck;
    logic [6:0] vec;
    pif.req_on = 1'b0;
    pif.pwr_ack = 1'b0;

    // Reset
    step();
    vec = {pif.iso, pif.pwr_en, pif.clken, pif.dom_rst, pif.is_on, pif.busy, pif.err};
    expect_bit("reset_vec", vec === 7'b1001000, 1'b1);
    rst = 1'b0;
    step();

    // Power-up: req at edge 0, ack sampled at edge 3
    pif.req_on = 1'b1;
    step();                                     // edge 0
    expect_bit("pu_pwr_en", pif.pwr_en, 1'b1);
    step(); step();
    pif.pwr_ack = 1'b1;
    step();                                     // edge 3
    expect_bit("pu_clken", pif.clken, 1'b1);
    step(); step(); step();                     // edge 6
    expect_bit("pu_dom_rst", pif.dom_rst, 1'b0);
    expect_bit("pu_iso_held", pif.iso, 1'b1);
    step(); step();                             // edge 8
    expect_bit("pu_iso", pif.iso, 1'b0);
    expect_bit("pu_is_on", pif.is_on, 1'b1);
    expect_bit("pu_busy", pif.busy, 1'b0);

    // Power-down: req drops at edge 0, ack drops at edge 7
    pif.req_on = 1'b0;
    step();                                     // edge 0
    expect_bit("pd_iso", pif.iso, 1'b1);
    step(); step();                             // edge 2
    expect_bit("pd_clken", pif.clken, 1'b0);
    expect_bit("pd_dom_rst", pif.dom_rst, 1'b1);
    step(); step(); step();                     // edge 5
    expect_bit("pd_pwr_en", pif.pwr_en, 1'b0);
    step();
    pif.pwr_ack = 1'b0;
    step();                                     // edge 7
    expect_bit("pd_busy", pif.busy, 1'b0);
    expect_bit("pd_is_on", pif.is_on, 1'b0);

    // Power-up timeout, then retry with req_on still high
    pif.req_on = 1'b1;
    step();                                     // edge 0
    repeat (8) step();                          // edge 8
    expect_bit("to_err", pif.err, 1'b1);
    expect_bit("to_pwr_en", pif.pwr_en, 1'b0);
    step();                                     // edge 9: PWRUP again
    expect_bit("retry_pwr_en", pif.pwr_en, 1'b1);
    expect_bit("retry_err", pif.err, 1'b0);

    // Ack exactly on the timeout edge wins
    repeat (7) step();
    pif.pwr_ack = 1'b1;
    step();
    expect_bit("ackwin_clken", pif.clken, 1'b1);
    expect_bit("ackwin_err", pif.err, 1'b0);

    // req_on drops during RSTREL: finish to ON, then start power-down
    pif.req_on = 1'b0;
    repeat (5) step();
    expect_bit("midreq_is_on", pif.is_on, 1'b1);
    step();
    expect_bit("midreq_iso", pif.iso, 1'b1);
    expect_bit("midreq_busy", pif.busy, 1'b1);
    repeat (5) step();
    expect_bit("pdto_pwr_en", pif.pwr_en, 1'b0);
    repeat (8) step();                          // ack never dropped
    expect_bit("pdto_err", pif.err, 1'b1);
    expect_bit("pdto_busy", pif.busy, 1'b0);
    step();
    expect_bit("pdto_err_sticky", pif.err, 1'b1);

    // Reset in ISOREL
    pif.req_on = 1'b1;
    step(); step();
    repeat (3) step();
    expect_bit("isorel_dom_rst", pif.dom_rst, 1'b0);
    rst = 1'b1;
    step();
    vec = {pif.iso, pif.pwr_en, pif.clken, pif.dom_rst, pif.is_on, pif.busy, pif.err};
    expect_bit("midrst_vec", vec === 7'b1001000, 1'b1);
    rst = 1'b0;
    pif.req_on = 1'b0;
    pif.pwr_ack = 1'b0;
    step();

    // Randomized traffic; ack mostly tracks pwr_en, with stuck windows
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) pif.req_on = ~pif.req_on;
      if (stuck > 0) stuck--;
      else if ($urandom_range(0, 79) == 0) stuck = 12;
      else if (pif.pwr_en) pif.pwr_ack = ($urandom_range(0, 3) != 0);
      else pif.pwr_ack = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/la_pwrseq.md
Name: la_pwrseq

Overview:
Power-domain sequencer FSM for one switchable domain. It generates the isolation control that drives the la_visolo/la_isolo cells on the domain boundary. It also generates the power-switch enable, domain clock enable and domain reset, ordered so that isolation always covers any interval where the domain is unpowered, unclocked or in reset. It sits in the always-on domain, upstream of the vectorized isolation cells.

Parameters:
ISO_DLY, 2, cycles between an iso edge and the next sequence step (>=1)
RST_DLY, 4, cycles the domain is clocked while held in reset on power-up, and clock-stop settle on power-down (>=1)
PWR_TO, 16, timeout in cycles waiting for pwr_ack (0 = no timeout)
CW, 8, width of the internal delay/timeout counter (must hold max(ISO_DLY, RST_DLY, PWR_TO))

Ports:
clk  input  1  always-on clock
rst  input  1  synchronous active-high reset
req_on  input  1  level request: 1 = domain on, 0 = domain off
pwr_ack  input  1  power-switch chain feedback (1 = domain fully powered)
iso  output  1  isolation enable to la_visolo.iso (1 = outputs clamped low)
pwr_en  output  1  power-switch enable
clken  output  1  domain clock enable
dom_rst  output  1  domain reset, active-high
is_on  output  1  1 only in state ON
busy  output  1  1 in any transitional state
err  output  1  sticky pwr_ack timeout flag

Behaviour:
- Decided: one clock, clk; reset rst is synchronous, active-high.
- All outputs are flops updated on the same edge as the state register. There is no combinational path from inputs to outputs.
- Reset (rst=1 at an edge) enters OFF from any state, including mid-sequence: iso=1, pwr_en=0, clken=0, dom_rst=1, is_on=0, busy=0, err=0, counter=0.
- States and outputs (iso/pwr_en/clken/dom_rst):
  - OFF 1/0/0/1
  - PWRUP 1/1/0/1
  - RSTREL 1/1/1/1
  - ISOREL 1/1/1/0
  - ON 0/1/1/0
  - ISOSET 1/1/1/0
  - CLKOFF 1/1/0/1
  - PWRDN 1/0/0/1
- busy=1 in PWRUP, RSTREL, ISOREL, ISOSET, CLKOFF and PWRDN.
- Timed state entered at edge e exits at edge e+DLY. The counter clears on every state entry.
- Power-up sequence:
  - OFF & req_on=1 -> PWRUP; err clears on this edge.
  - PWRUP & pwr_ack=1 -> RSTREL.
  - RSTREL after RST_DLY -> ISOREL.
  - ISOREL after ISO_DLY -> ON.
- Power-down sequence:
  - ON & req_on=0 -> ISOSET.
  - ISOSET after ISO_DLY -> CLKOFF.
  - CLKOFF after RST_DLY -> PWRDN.
  - PWRDN & pwr_ack=0 -> OFF.
- req_on is sampled only in OFF and ON. A sequence always runs to completion; a request change mid-sequence is acted on after arrival in ON/OFF.
- Timeouts (PWR_TO>0):
  - PWRUP entered at edge e with no pwr_ack=1 sampled by edge e+PWR_TO -> OFF with err=1.
  - PWRDN with no pwr_ack=0 sampled by edge e+PWR_TO -> OFF with err=1.
  - pwr_ack sampled on the timeout edge wins, so no error is flagged.
- err stays set through OFF until rst or the next OFF->PWRUP transition. If req_on is still 1 after a timeout, power-up retries on the next edge.
- Invariant: iso=1 whenever pwr_en=0, clken=0 or dom_rst=1. iso falls only on ISOREL->ON and rises only on ON->ISOSET.
- The counter saturates; it never wraps in any state.

Test Plan:
- Power-up (ISO_DLY=2, RST_DLY=3, PWR_TO=8): rst, then req_on=1 at edge 0 and pwr_ack=1 sampled at edge 3 -> pwr_en=1 after edge 0, clken=1 after edge 3, dom_rst=0 after edge 6, iso=0 and is_on=1 after edge 8, busy=0.
- Power-down from ON with req_on=0 at edge 0 -> iso=1 after edge 0, clken=0 and dom_rst=1 after edge 2, pwr_en=0 after edge 5. pwr_ack=0 at edge 7 -> OFF after edge 7, busy=0.
- Timeout: pwr_ack held 0 with PWR_TO=8 and PWRUP entered at edge 0 -> OFF with err=1 and pwr_en=0 after edge 8. Then PWRUP re-entered after edge 9 (req_on=1) with err=0.
- Ack on the timeout edge: pwr_ack=1 first sampled at edge 8 -> RSTREL, err stays 0.
- req_on toggled 1->0 during RSTREL -> power-up completes to ON, then power-down begins on the next edge. iso never reads 0 while dom_rst=1.
- rst asserted in ISOREL -> all outputs equal reset values after that edge. Monitor checks the iso invariant every cycle in every test.
